// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory bus arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic arb_state_t own_state(input logic m);
    return m ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin pick for the idle state, plus the rr_last history bit.
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic req0,
  input  logic req1,
  input  logic force_set,
  input  logic force_val,
  output logic pick,
  output logic pick_valid
);

  logic rr_last;
  logic tie;

  assign tie = req0 & req1;

  always_comb begin
    pick_valid = arb_en & (req0 | req1);
    pick       = M0;
    if (tie) begin
      pick = ~rr_last;
    end else if (req1) begin
      pick = M1;
    end
  end

  // History only moves on an idle tie or on a forced hold-limit release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= M1;
    end else if (arb_en && tie) begin
      rr_last <= pick;
    end else if (force_set) begin
      rr_last <= force_val;
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Arbitrates two masters onto one data-memory port with locked ownership,
// a per-owner hold limit and out-of-range error responses.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned    HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_ONE = HW'(1);
  localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD);

  arb_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;
  logic          at_limit;

  logic          pick;
  logic          pick_valid;
  logic          gnt_any;
  logic          sel;
  logic          sel_lock;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic          oor;
  logic          is_read;
  logic          resp;
  logic          forced;

  dm_arb_rr u_rr (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (reset && (state == ST_IDLE)),
    .req0       (m0_req),
    .req1       (m1_req),
    .force_set  (forced),
    .force_val  (sel),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // The grant is combinational so the access lands on the same edge it is won.
  always_comb begin
    sel     = pick;
    gnt_any = 1'b0;
    case (state)
      ST_IDLE: begin
        sel     = pick;
        gnt_any = pick_valid;
      end
      ST_OWN0: begin
        sel     = M0;
        gnt_any = m0_req;
      end
      ST_OWN1: begin
        sel     = M1;
        gnt_any = m1_req;
      end
      default: begin
        sel     = M0;
        gnt_any = 1'b0;
      end
    endcase
    if (!reset) begin
      gnt_any = 1'b0;
    end
  end

  assign sel_lock  = sel ? m1_lock   : m0_lock;
  assign sel_addr  = sel ? m1_addr   : m0_addr;
  assign sel_wdata = sel ? m1_wdata  : m0_wdata;
  assign sel_be    = sel ? m1_byteen : m0_byteen;

  assign oor     = (sel_addr >= DM_LIMIT);
  assign is_read = (sel_be == '0);
  assign resp    = gnt_any && (is_read || oor);

  assign hold_inc = hold_cnt + HOLD_ONE;
  assign at_limit = (hold_inc == HOLD_LIM);
  assign forced   = gnt_any && (state != ST_IDLE) && at_limit;

  assign m0_gnt = gnt_any && (sel == M0);
  assign m1_gnt = gnt_any && (sel == M1);

  assign mem_addr   = gnt_any ? sel_addr  : '0;
  assign mem_wdata  = gnt_any ? sel_wdata : '0;
  assign mem_byteen = (gnt_any && !oor) ? sel_be : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= resp && (sel == M0);
      m1_rvalid <= resp && (sel == M1);
      m0_err    <= gnt_any && oor && (sel == M0);
      m1_err    <= gnt_any && oor && (sel == M1);
      if (resp) begin
        if (sel == M1) begin
          m1_rdata <= oor ? '0 : mem_rdata;
        end else begin
          m0_rdata <= oor ? '0 : mem_rdata;
        end
      end

      case (state)
        ST_IDLE: begin
          if (gnt_any && sel_lock && (MAX_HOLD > 1)) begin
            state    <= own_state(sel);
            hold_cnt <= HOLD_ONE;
          end else begin
            hold_cnt <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // A missing request releases without an access; otherwise the
          // access counts toward the hold limit before any release.
          if (!gnt_any || !sel_lock || at_limit) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_inc;
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of ownership, round-robin and memory.
module tb_dm_bus_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam logic [31:0] LIMIT    = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req  [2];
  logic        lock [2];
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [3:0]  be   [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  logic [31:0] mem [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .DM_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_byteen(be[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_byteen(be[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata)
  );

  // Data memory environment: combinational read, byte-lane write at the edge.
  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lock[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end
  endtask

  // Leaves time at one unit after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req[0] = 1; req[1] = 1; addr[0] = 32'h10; addr[1] = 32'h10;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL reset_pre_gnt: got %b want 01", {m1_gnt, m0_gnt});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
                        {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err});
    end
    n_cmp++;
    if ({mem_byteen, mem_addr, m0_rdata, m1_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: byteen %h addr %h rd0 %h rd1 %h want all 0",
                        mem_byteen, mem_addr, m0_rdata, m1_rdata);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_tie_read();
    logic [31:0] v;
    do_reset();
    v = $urandom;
    mem[4] = v;
    req[0] = 1; req[1] = 1; addr[0] = 32'h10; addr[1] = 32'h10;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_addr !== 32'h10 || mem_byteen !== 4'h0) begin
      n_bad++; $display("FAIL tie_cycle1: gnt %b addr %h be %h want 01 00000010 0",
                        {m1_gnt, m0_gnt}, mem_addr, mem_byteen);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== v) begin
      n_bad++; $display("FAIL tie_m0_rvalid: rv %b/%b rdata %h want 1/0 %h",
                        m0_rvalid, m1_rvalid, m0_rdata, v);
    end
    req[0] = 0;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL tie_cycle2: gnt %b want 10", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== v) begin
      n_bad++; $display("FAIL tie_m1_rvalid: rv %b/%b rdata %h want 1/0 %h",
                        m1_rvalid, m0_rvalid, m1_rdata, v);
    end
    req[1] = 0;
    @(posedge clk); #1;
    n_cmp++;
    if ({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt} !== 4'b0) begin
      n_bad++; $display("FAIL tie_pulse_end: got %b want 0000",
                        {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt});
    end
  endtask

  task automatic test_partial_write();
    do_reset();
    mem[8] = 32'h1122_3344;
    req[0] = 1; addr[0] = 32'h20; wdata[0] = 32'hAABB_CCDD; be[0] = 4'b0011;
    #2;
    n_cmp++;
    if (m0_gnt !== 1'b1 || mem_byteen !== 4'b0011 || mem_wdata !== 32'hAABB_CCDD) begin
      n_bad++; $display("FAIL pw_write: gnt %b be %b wdata %h want 1 0011 aabbccdd",
                        m0_gnt, mem_byteen, mem_wdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      n_bad++; $display("FAIL pw_no_rvalid: rv %b rdata %h want 0 00000000", m0_rvalid, m0_rdata);
    end
    be[0] = 4'b0000;
    #2;
    @(posedge clk); #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1122_CCDD) begin
      n_bad++; $display("FAIL pw_readback: rv %b rdata %h want 1 1122ccdd", m0_rvalid, m0_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_lock_limit();
    int exp_seq[7] = '{0, 0, 0, 0, 1, 0, 0};
    int left0 = 6;
    int left1 = 1;
    int g;
    do_reset();
    req[0] = 1; lock[0] = 1; addr[0] = 32'h40;
    req[1] = 1; addr[1] = 32'h44;
    for (int c = 0; c < 7; c++) begin
      #2;
      g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      n_cmp++;
      if (g != exp_seq[c] || (m0_gnt && m1_gnt)) begin
        n_bad++; $display("FAIL lock_seq[%0d]: granted %0d (gnt %b) want %0d",
                          c, g, {m1_gnt, m0_gnt}, exp_seq[c]);
      end
      @(posedge clk); #1;
      if (g == 0) left0--;
      if (g == 1) left1--;
      if (left0 <= 0) req[0] = 0;
      if (left1 <= 0) req[1] = 0;
    end
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    mem[12'hBFF] = 32'hDEAD_BEEF;
    req[1] = 1; addr[1] = 32'h2FFC;
    #2;
    @(posedge clk); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL oor_last_word: rv %b err %b rdata %h want 1 0 deadbeef",
                        m1_rvalid, m1_err, m1_rdata);
    end
    addr[1] = 32'h3000;
    #2;
    n_cmp++;
    if (m1_gnt !== 1'b1 || mem_byteen !== 4'h0) begin
      n_bad++; $display("FAIL oor_read_gnt: gnt %b be %h want 1 0", m1_gnt, mem_byteen);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0 || m0_err !== 1'b0) begin
      n_bad++; $display("FAIL oor_read_resp: rv %b err %b rdata %h m0_err %b want 1 1 0 0",
                        m1_rvalid, m1_err, m1_rdata, m0_err);
    end
    addr[1] = 32'h3004; be[1] = 4'hF; wdata[1] = 32'h1234_5678;
    #2;
    n_cmp++;
    if (m1_gnt !== 1'b1 || mem_byteen !== 4'h0) begin
      n_bad++; $display("FAIL oor_write_gnt: gnt %b be %h want 1 0", m1_gnt, mem_byteen);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b1) begin
      n_bad++; $display("FAIL oor_write_resp: rv %b err %b want 1 1", m1_rvalid, m1_err);
    end
    clear_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b0 || m1_err !== 1'b0) begin
      n_bad++; $display("FAIL oor_pulse: rv %b err %b want 0 0", m1_rvalid, m1_err);
    end
  endtask

  task automatic test_reset_in_own();
    do_reset();
    req[0] = 1; req[1] = 1; addr[0] = 32'h10; addr[1] = 32'h14;
    #2;
    @(posedge clk); #1;
    req[0] = 0; lock[1] = 1;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rio_take: gnt %b want 10", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    req[0] = 1;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rio_owner_only: gnt %b want 10", {m1_gnt, m0_gnt});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt, m1_rvalid, mem_byteen} !== 7'b0) begin
      n_bad++; $display("FAIL rio_async_clear: gnt %b rv %b be %h want 00 0 0",
                        {m1_gnt, m0_gnt}, m1_rvalid, mem_byteen);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    lock[1] = 0;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || m1_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rio_tie_after: gnt %b rv1 %b want 01 0", {m1_gnt, m0_gnt}, m1_rvalid);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_release();
    do_reset();
    req[0] = 1; lock[0] = 1; addr[0] = 32'h10;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL rel_take: gnt %b want 01", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    req[0] = 0; req[1] = 1; addr[1] = 32'h14;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      n_bad++; $display("FAIL rel_gap: gnt %b want 00", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    #2;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rel_next: gnt %b want 10", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Reference model state for randomized traffic.
  int          own;
  int          hold;
  int          rr;
  logic [31:0] ref_mem [0:63];

  task automatic new_txn(input int m);
    int unsigned w;
    w = $urandom_range(0, 63);
    req[m]   = 1'b1;
    lock[m]  = 1'($urandom_range(0, 1));
    wdata[m] = $urandom;
    be[m]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    case ($urandom_range(0, 9))
      0:       addr[m] = LIMIT + (w << 2);
      1:       addr[m] = 32'hFFFF_FFFC;
      default: addr[m] = w << 2;
    endcase
  endtask

  task automatic test_random();
    int          g;
    logic        tie;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic [31:0] e_rd [2];
    logic [31:0] rd_act [2];
    for (int w = 0; w < 64; w++) begin
      ref_mem[w] = $urandom;
      mem[w] = ref_mem[w];
    end
    do_reset();
    own = -1; hold = 0; rr = 1;
    e_rd[0] = '0; e_rd[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 3) != 0) new_txn(m);

      g = -1;
      tie = 1'b0;
      if (own < 0) begin
        if (req[0] && req[1]) begin g = (rr == 0) ? 1 : 0; tie = 1'b1; end
        else if (req[0]) g = 0;
        else if (req[1]) g = 1;
      end else if (req[own]) begin
        g = own;
      end

      e_gnt = 2'b00; e_be = 4'h0; e_addr = '0; e_wd = '0;
      if (g >= 0) begin
        e_gnt[g] = 1'b1;
        e_addr = addr[g];
        e_wd = wdata[g];
        if (addr[g] < LIMIT) e_be = be[g];
      end

      #2;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== e_gnt) begin
        n_bad++; $display("FAIL rnd_gnt @%0d: got %b want %b", cyc, {m1_gnt, m0_gnt}, e_gnt);
      end
      n_cmp++;
      if (mem_byteen !== e_be || mem_addr !== e_addr || mem_wdata !== e_wd) begin
        n_bad++; $display("FAIL rnd_mem @%0d: be %h addr %h wd %h want %h %h %h",
                          cyc, mem_byteen, mem_addr, mem_wdata, e_be, e_addr, e_wd);
      end

      e_rv = 2'b00; e_err = 2'b00;
      if (g >= 0) begin
        if (addr[g] >= LIMIT) begin
          e_rv[g] = 1'b1; e_err[g] = 1'b1; e_rd[g] = '0;
        end else if (be[g] == 4'h0) begin
          e_rv[g] = 1'b1; e_rd[g] = ref_mem[addr[g][7:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[g][b]) ref_mem[addr[g][7:2]][8*b +: 8] = wdata[g][8*b +: 8];
        end
        if (own < 0) begin
          if (tie) rr = g;
          if (lock[g]) begin own = g; hold = 1; end
        end else begin
          hold++;
          if (hold == int'(MAX_HOLD)) begin rr = own; own = -1; hold = 0; end
          else if (!lock[g]) begin own = -1; hold = 0; end
        end
      end else if (own >= 0) begin
        own = -1; hold = 0;
      end

      @(posedge clk); #1;
      rd_act[0] = m0_rdata; rd_act[1] = m1_rdata;
      n_cmp++;
      if ({m1_rvalid, m0_rvalid} !== e_rv || {m1_err, m0_err} !== e_err) begin
        n_bad++; $display("FAIL rnd_resp @%0d: rv %b err %b want %b %b",
                          cyc, {m1_rvalid, m0_rvalid}, {m1_err, m0_err}, e_rv, e_err);
      end
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (rd_act[m] !== e_rd[m]) begin
          n_bad++; $display("FAIL rnd_rdata%0d @%0d: got %h want %h", m, cyc, rd_act[m], e_rd[m]);
        end
      end
      if (g >= 0) req[g] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int w = 0; w < 4096; w++) mem[w] = '0;
    test_reset();
    test_tie_read();
    test_partial_write();
    test_lock_limit();
    test_out_of_range();
    test_reset_in_own();
    test_release();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
